wrr_burst_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one transaction-oriented resource (bus port, memory bank) between NUM_REQ requesters.
- A winner holds a locked grant until it signals transaction end on done_i.
- The same owner may be regranted back-to-back up to its programmed weight, then priority rotates.
- Sits upstream of the shared resource, replacing a plain single-cycle round-robin arbiter where transactions are multi-cycle.

---
 rtl/wrr_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 45 ++++
 rtl/wrr_burst_arbiter.sv | 127 ++++++++++++
 tb/tb_wrr_burst_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin burst arbiter.
//   - arb_state_e : arbiter FSM states
//   - eff_weight  : maps a programmed weight to its effective burst limit
//   - DEF_*       : default parameter values for the arbiter
package wrr_arb_pkg;

   localparam int unsigned DEF_NUM_REQ  = 4;
   localparam int unsigned DEF_WEIGHT_W = 4;
   // Widest weight field eff_weight accepts; WEIGHT_W must not exceed this.
   localparam int unsigned MAX_WEIGHT_W = 16;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // A weight of zero still allows one grant per turn.
   function automatic logic [MAX_WEIGHT_W-1:0] eff_weight(input logic [MAX_WEIGHT_W-1:0] w);
      return (w == '0) ? MAX_WEIGHT_W'(1) : w;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: first set bit of req at or above start,
// wrapping modulo NUM_REQ.
//   req      : request vector
//   start    : index with highest priority
//   found    : at least one request is set
//   pick_oh  : one-hot winner (zero when !found)
//   pick_idx : binary winner index (zero when !found)
module rr_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   output logic               found,
   output logic [NUM_REQ-1:0] pick_oh,
   output logic [IDX_W-1:0]   pick_idx
);

   localparam int unsigned DBL_W = 2 * NUM_REQ;

   logic [DBL_W-1:0] req_dbl;
   logic [DBL_W-1:0] mask;
   logic [DBL_W-1:0] masked;

   // Doubling the vector turns the wrap-around search into a plain
   // lowest-set-bit search once bits below start are masked off.
   assign req_dbl = {req, req};
   assign mask    = ~((DBL_W'(1) << start) - DBL_W'(1));
   assign masked  = req_dbl & mask;

   // Lowest set bit of the masked vector, folded back into range.
   always_comb begin
      found    = 1'b0;
      pick_idx = '0;
      for (int unsigned j = 0; j < DBL_W; j++) begin
         if (!found && masked[j]) begin
            found    = 1'b1;
            pick_idx = (j < NUM_REQ) ? IDX_W'(j) : IDX_W'(j - NUM_REQ);
         end
      end
   end

   assign pick_oh = found ? (NUM_REQ'(1) << pick_idx) : '0;

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter for multi-cycle transactions. The winner
// keeps a locked grant until done_i; it may be regranted back-to-back up
// to its weight, after which priority rotates past it.
//   clk_i, rst_ni : clock, async active-low reset
//   req_i         : per-requester level request
//   done_i        : current owner's transaction ends this cycle
//   weight_i      : per-requester max consecutive grants (0 acts as 1)
//   gnt_o         : registered one-hot grant
//   gnt_idx_o     : registered owner index, valid when busy_o
//   busy_o        : registered, equals |gnt_o
module wrr_burst_arbiter
   import wrr_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ  = DEF_NUM_REQ,
   parameter  int unsigned WEIGHT_W = DEF_WEIGHT_W,
   localparam int unsigned IDX_W    = $clog2(NUM_REQ)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic                         done_i,
   input  logic [NUM_REQ*WEIGHT_W-1:0]  weight_i,
   output logic [NUM_REQ-1:0]           gnt_o,
   output logic [IDX_W-1:0]             gnt_idx_o,
   output logic                         busy_o
);

   arb_state_e          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                busy_q, busy_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [WEIGHT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0]    next_owner;
   logic [IDX_W-1:0]    pick_start;
   logic [WEIGHT_W-1:0] owner_weight;
   logic [WEIGHT_W-1:0] owner_weff;
   logic                pick_found;
   logic [NUM_REQ-1:0]  pick_oh;
   logic [IDX_W-1:0]    pick_idx;

   // Rotation starts just past the owner so the owner is considered last.
   assign next_owner   = (32'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + IDX_W'(1);
   assign pick_start   = (state_q == ST_IDLE) ? ptr_q : next_owner;
   assign owner_weight = weight_i[32'(idx_q) * WEIGHT_W +: WEIGHT_W];
   assign owner_weff   = WEIGHT_W'(eff_weight(MAX_WEIGHT_W'(owner_weight)));

   rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req      (req_i),
      .start    (pick_start),
      .found    (pick_found),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_found) begin
               state_d = ST_GRANT;
               gnt_d   = pick_oh;
               idx_d   = pick_idx;
               busy_d  = 1'b1;
               cnt_d   = WEIGHT_W'(1);
            end
         end
         ST_GRANT: begin
            if (done_i) begin
               if (req_i[idx_q] && (cnt_q < owner_weff)) begin
                  // Burst continues with the same owner, no bubble.
                  cnt_d = cnt_q + WEIGHT_W'(1);
               end else begin
                  ptr_d = next_owner;
                  if (pick_found) begin
                     gnt_d = pick_oh;
                     idx_d = pick_idx;
                     cnt_d = WEIGHT_W'(1);
                  end else begin
                     state_d = ST_IDLE;
                     gnt_d   = '0;
                     idx_d   = '0;
                     busy_d  = 1'b0;
                     cnt_d   = '0;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign gnt_idx_o = idx_q;
   assign busy_o    = busy_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter: reset, directed grant tables,
// lock/weight/wrap/async-reset sequences and a randomized run against a
// queue-free behavioural model of the arbitration rules.
module tb_wrr_burst_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned WW = 4;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic [N-1:0]    req_i;
   logic            done_i;
   logic [N*WW-1:0] weight_i;
   logic [N-1:0]    gnt_o;
   logic [1:0]      gnt_idx_o;
   logic            busy_o;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   bit m_busy  = 1'b0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_cnt   = 0;
   bit m_event = 1'b0;

   typedef struct {
      logic [N-1:0] req;
      logic         done;
      logic [N-1:0] gnt;
      logic [1:0]   idx;
   } vec_t;

   vec_t vecs[24];
   int   exp_own[24] = '{0,0,0,0,0, 1,1,1,1,1,1, 2,2,2,2,2,2, 3,3,3,3,3,3, 0};
   int   seq4[8]     = '{2,3,3,3,2,3,3,3};

   always #5 clk_i = ~clk_i;

   wrr_burst_arbiter #(
      .NUM_REQ  (N),
      .WEIGHT_W (WW)
   ) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .req_i     (req_i),
      .done_i    (done_i),
      .weight_i  (weight_i),
      .gnt_o     (gnt_o),
      .gnt_idx_o (gnt_idx_o),
      .busy_o    (busy_o)
   );

   function automatic int weff(input int i);
      int w;
      w = int'(weight_i[i*WW +: WW]);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic int pick_from(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         int i;
         i = (start + k) % N;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_event = 1'b0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic d);
      m_event = 1'b0;
      if (!m_busy) begin
         if (r != 0) begin
            m_owner = pick_from(r, m_ptr);
            m_busy  = 1'b1;
            m_cnt   = 1;
            m_event = 1'b1;
         end
      end else if (d) begin
         m_event = 1'b1;
         if (r[m_owner] && m_cnt < weff(m_owner)) begin
            m_cnt++;
         end else begin
            m_ptr = (m_owner + 1) % N;
            if (r != 0) begin
               m_owner = pick_from(r, m_ptr);
               m_cnt   = 1;
            end else begin
               m_busy  = 1'b0;
               m_event = 1'b0;
            end
         end
      end
   endtask

   task automatic check_out(input string name, input logic [N-1:0] eg,
                            input logic [1:0] ei, input logic eb);
      n_checks++;
      if (gnt_o !== eg || busy_o !== eb || (eb && gnt_idx_o !== ei)) begin
         n_errors++;
         $display("FAIL %s: got gnt=%b idx=%0d busy=%b, expected gnt=%b idx=%0d busy=%b",
                  name, gnt_o, gnt_idx_o, busy_o, eg, ei, eb);
      end
   endtask

   task automatic check_model(input string name);
      logic [N-1:0] eg;
      eg = m_busy ? (N'(1) << m_owner) : '0;
      check_out(name, eg, 2'(m_owner), m_busy);
      n_checks++;
      if (!$onehot0(gnt_o)) begin
         n_errors++;
         $display("FAIL onehot: got gnt=%b, expected zero or one-hot", gnt_o);
      end
   endtask

   // Drive one cycle of inputs, advance model at the edge, sample after it.
   task automatic cycle(input logic [N-1:0] r, input logic d, input string name);
      req_i  = r;
      done_i = d;
      @(posedge clk_i);
      model_step(r, d);
      #1;
      check_model(name);
   endtask

   task automatic apply_reset(input int cycles);
      rst_ni = 1'b0;
      req_i  = '0;
      done_i = 1'b0;
      model_reset();
      repeat (cycles) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   initial begin
      logic [N-1:0] r;
      logic         d;
      int           wait_cnt[N];
      int           bound;
      bit           starve;
      int           worst;

      for (int k = 0; k < 24; k++)
         vecs[k] = '{req: 4'b1111, done: 1'(k % 3 == 2),
                     gnt: N'(1) << exp_own[k], idx: 2'(exp_own[k])};

      // Reset held with all requests active
      rst_ni   = 1'b0;
      req_i    = 4'b1111;
      done_i   = 1'b0;
      weight_i = 16'h2222;
      model_reset();
      for (int k = 0; k < 10; k++) begin
         @(posedge clk_i);
         #1;
         check_out("reset_hold", '0, 2'd0, 1'b0);
      end
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Weight-2 bursts with done every third cycle
      for (int k = 0; k < 24; k++) begin
         cycle(vecs[k].req, vecs[k].done, "table_model");
         check_out($sformatf("table_%0d", k), vecs[k].gnt, vecs[k].idx, 1'b1);
      end

      // Grant stays locked while the owner's request is low
      apply_reset(2);
      cycle(4'b0010, 1'b0, "lock_model");
      check_out("lock_grant", 4'b0010, 2'd1, 1'b1);
      for (int k = 0; k < 5; k++) begin
         cycle(4'b0000, 1'b0, "lock_model");
         check_out("lock_hold", 4'b0010, 2'd1, 1'b1);
      end
      cycle(4'b0000, 1'b1, "lock_model");
      check_out("lock_release", '0, 2'd0, 1'b0);
      cycle(4'b0000, 1'b0, "lock_model");
      check_out("idle_after_release", '0, 2'd0, 1'b0);

      // Zero weight behaves as one
      weight_i = 16'h3033;
      apply_reset(2);
      for (int k = 0; k < 8; k++) begin
         cycle(4'b1100, 1'b1, "w0_model");
         check_out($sformatf("w0_seq_%0d", k), N'(1) << seq4[k], 2'(seq4[k]), 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
         cycle(4'b0100, 1'b1, "sole_model");
         check_out("sole_w0", 4'b0100, 2'd2, 1'b1);
      end

      // Pointer wraps after owner 3
      weight_i = 16'h1111;
      apply_reset(2);
      cycle(4'b1000, 1'b0, "wrap_model");
      check_out("wrap_owner3", 4'b1000, 2'd3, 1'b1);
      cycle(4'b1001, 1'b1, "wrap_model");
      check_out("wrap_to_0", 4'b0001, 2'd0, 1'b1);

      // Async reset between edges while granted
      #2;
      rst_ni = 1'b0;
      #1;
      check_out("async_reset", '0, 2'd0, 1'b0);
      model_reset();
      req_i  = '0;
      done_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cycle(4'b0110, 1'b0, "post_reset_model");
      check_out("post_reset_ptr0", 4'b0010, 2'd1, 1'b1);

      // Randomized run with sticky requests and a starvation bound
      r      = 4'b0110;
      starve = 1'b0;
      worst  = 0;
      bound  = 0;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
      for (int c = 0; c < 1000; c++) begin
         if (c % 250 == 0) begin
            weight_i = 16'($urandom);
            foreach (wait_cnt[i]) wait_cnt[i] = 0;
            bound = 0;
            for (int i = 0; i < N; i++) bound += weff(i);
         end
         for (int i = 0; i < N; i++) begin
            if (r[i] && !(m_busy && m_owner == i)) r[i] = 1'b1;
            else if (m_busy && m_owner == i)      r[i] = 1'($urandom_range(0, 1));
            else                                  r[i] = ($urandom_range(0, 3) == 0);
         end
         d = ($urandom_range(0, 2) == 0);
         cycle(r, d, "random_model");
         for (int i = 0; i < N; i++) begin
            if (!r[i] || (m_busy && m_owner == i)) wait_cnt[i] = 0;
            else if (m_event) wait_cnt[i]++;
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
            if (wait_cnt[i] > bound) starve = 1'b1;
         end
      end
      n_checks++;
      if (starve) begin
         n_errors++;
         $display("FAIL starvation: worst wait %0d grants, expected at most sum of weights", worst);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
